vivado_demo_checker: RTL and testbench
======================================

// Module: vivado_demo_checker
// PURPOSE
//  Receive-side checker for the vivado_demo 8-bit count stream. Samples the demo's out[7:0]
//  on every enabled clock and confirms each sample is the previous one +1 (mod 2^WIDTH).
//  Declares lock after a run of good samples, then counts mismatches and sets a sticky fault.
//  Sits next to vivado_demo in the same clock domain; status goes to ILA/LEDs or a bench scoreboard.
// PARAMETERS
//  WIDTH    8   data width of the checked stream
//  LOCK_CNT 4   consecutive matching samples needed to assert locked (>=1)
//  MAX_ERR  8   mismatches in TRACK before fault is set (>=1)
//  ERR_W    16  err_count width, saturating
//  CNT_W    32  good_count width, saturating
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  reset       in   1      asynchronous, active-low (0 = reset)
//  enable      in   1      sample qualifier, same enable that drives vivado_demo
//  data_in     in   WIDTH  vivado_demo out stream
//  clr_stats   in   1      sync clear of counters/fault, returns to IDLE
//  locked      out  1      stream is tracking
//  mismatch    out  1      one-cycle pulse per TRACK mismatch
//  fault       out  1      sticky, err_count reached MAX_ERR
//  err_count   out  ERR_W  TRACK mismatches, saturating
//  good_count  out  CNT_W  matched samples in TRACK, saturating
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; every output is 0; expected=0; streak=0.
//  - All outputs registered, updated 1 clk after the sampled edge. A sample is data_in at a
//    rising edge with enable=1.
//  - match = (data_in == expected). expected is a WIDTH-bit reg, so 0xFF+1 wraps to 0x00,
//    and that wrap is a match.
//  - After every sample, expected <= data_in+1, whether or not the sample matched.
//  - FSM states:
//    IDLE : enable=1 -> load expected, streak=0, go to SYNC.
//           First sample is never checked.
//    SYNC : match -> streak++. When streak reaches LOCK_CNT -> TRACK, locked<=1.
//           Mismatch -> streak=0, stay in SYNC. No err_count change, no mismatch pulse.
//    TRACK: match -> good_count++ (saturating).
//           Mismatch -> mismatch<=1 for 1 cycle, err_count++ (saturating).
//           If the new err_count >= MAX_ERR -> FAULT.
//    FAULT: fault=1, locked=0. Samples are ignored, counters frozen.
//           Leaves only on clr_stats or reset.
//  - enable=0 in SYNC/TRACK -> IDLE at the next edge: locked<=0, streak=0.
//    err_count and good_count are kept. A pause and resume needs a full re-lock.
//  - clr_stats=1 beats every other event, including a same-cycle mismatch or enable.
//    Next edge: err_count=0, good_count=0, fault=0, locked=0, state=IDLE.
//  - Saturation: counters stop at all-ones, no wrap. fault is driven only by the MAX_ERR compare.
//  - Reset asserted mid-TRACK clears everything at once. No mismatch pulse is emitted.
// TESTING
//  T1 reset=0, then enable=1, data 0x10,0x11,..
//     -> locked=1 one cycle after sample 0x14 (LOCK_CNT=4); good_count counts from 0x15.
//  T2 lock, then stream 0xFD,0xFE,0xFF,0x00,0x01
//     -> no mismatch, err_count=0; good_count +5.
//  T3 locked at 0x20, inject 0x30 in place of 0x21, then 0x31
//     -> one mismatch pulse; err_count=1; 0x31 is a match; locked stays 1.
//  T4 8 non-consecutive bad samples while locked
//     -> fault=1 and locked=0 after the 8th; later samples leave err_count=8.
//     Then clr_stats=1 -> all counts 0, IDLE.
//  T5 enable low 3 cycles mid-TRACK, resume at 0x40
//     -> locked drops the next cycle and relocks after 4 matches; counters retained.
//  T6 clr_stats coincident with a mismatch -> err_count=0, no fault.
//     Also async reset mid-stream -> all outputs 0 without a clk edge.

Source files
------------

// File: rtl/vivado_demo_checker.sv
`default_nettype none
// ============================================================================
// Module      : vivado_demo_checker
// Description : Receive-side checker for the vivado_demo count stream. Locks
//               after a run of +1 samples, then counts matches/mismatches and
//               raises a sticky fault after too many mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module vivado_demo_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int MAX_ERR  = 8,
    parameter int ERR_W    = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_stats,
    output logic             locked,
    output logic             mismatch,
    output logic             fault,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] good_count
);

    localparam int                  STREAK_W    = $clog2(LOCK_CNT + 1);
    localparam logic [STREAK_W-1:0] LOCK_TARGET = STREAK_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0]    ERR_LIMIT   = ERR_W'(MAX_ERR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    expected_q, expected_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                locked_q, locked_d;
    logic                mismatch_q, mismatch_d;
    logic                fault_q, fault_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [CNT_W-1:0]    good_q, good_d;

    logic                w_match;
    logic [STREAK_W-1:0] w_streak_inc;
    logic [ERR_W-1:0]    w_err_inc;
    logic [CNT_W-1:0]    w_good_inc;

    assign w_match      = (data_in == expected_q);
    assign w_streak_inc = streak_q + STREAK_W'(1);
    assign w_err_inc    = (&err_q)  ? err_q  : err_q  + ERR_W'(1);
    assign w_good_inc   = (&good_q) ? good_q : good_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            expected_q <= '0;
            streak_q   <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            fault_q    <= 1'b0;
            err_q      <= '0;
            good_q     <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            streak_q   <= streak_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
            fault_q    <= fault_d;
            err_q      <= err_d;
            good_q     <= good_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        streak_d   = streak_q;
        locked_d   = locked_q;
        mismatch_d = 1'b0;
        fault_d    = fault_q;
        err_d      = err_q;
        good_d     = good_q;

        if (clr_stats) begin
            // Clearing outranks any sample seen on the same edge.
            state_d  = ST_IDLE;
            streak_d = '0;
            locked_d = 1'b0;
            fault_d  = 1'b0;
            err_d    = '0;
            good_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        expected_d = data_in + WIDTH'(1);
                        streak_d   = '0;
                        state_d    = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (!enable) begin
                        state_d  = ST_IDLE;
                        streak_d = '0;
                        locked_d = 1'b0;
                    end else begin
                        expected_d = data_in + WIDTH'(1);
                        if (w_match) begin
                            streak_d = w_streak_inc;
                            if (w_streak_inc == LOCK_TARGET) begin
                                state_d  = ST_TRACK;
                                locked_d = 1'b1;
                            end
                        end else begin
                            streak_d = '0;
                        end
                    end
                end
                ST_TRACK: begin
                    if (!enable) begin
                        state_d  = ST_IDLE;
                        streak_d = '0;
                        locked_d = 1'b0;
                    end else begin
                        expected_d = data_in + WIDTH'(1);
                        if (w_match) begin
                            good_d = w_good_inc;
                        end else begin
                            mismatch_d = 1'b1;
                            err_d      = w_err_inc;
                            if (w_err_inc >= ERR_LIMIT) begin
                                state_d  = ST_FAULT;
                                fault_d  = 1'b1;
                                locked_d = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    fault_d  = 1'b1;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    assign locked     = locked_q;
    assign mismatch   = mismatch_q;
    assign fault      = fault_q;
    assign err_count  = err_q;
    assign good_count = good_q;

endmodule
`default_nettype wire

// File: tb/tb_vivado_demo_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_vivado_demo_checker
// Description : Directed bench for vivado_demo_checker with a behavioural
//               stream model compared every cycle plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vivado_demo_checker;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  data_in;
    logic        clr_stats;
    logic        locked;
    logic        mismatch;
    logic        fault;
    logic [15:0] err_count;
    logic [31:0] good_count;

    int n_vec;
    int n_fail;

    vivado_demo_checker #(
        .WIDTH    (8),
        .LOCK_CNT (4),
        .MAX_ERR  (8),
        .ERR_W    (16),
        .CNT_W    (32)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .clr_stats  (clr_stats),
        .locked     (locked),
        .mismatch   (mismatch),
        .fault      (fault),
        .err_count  (err_count),
        .good_count (good_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream model: phase 0=waiting for first sample, 1=acquiring, 2=locked, 3=faulted
    int          m_phase;
    logic [7:0]  m_next;
    int          m_run;
    logic        m_locked;
    logic        m_mis;
    logic        m_fault;
    int          m_err;
    int          m_good;

    task automatic model_reset();
        m_phase  = 0;
        m_next   = 8'h00;
        m_run    = 0;
        m_locked = 1'b0;
        m_mis    = 1'b0;
        m_fault  = 1'b0;
        m_err    = 0;
        m_good   = 0;
    endtask

    task automatic model_edge(input logic en, input logic [7:0] d, input logic clr);
        m_mis = 1'b0;
        if (clr) begin
            m_phase = 0; m_run = 0; m_locked = 1'b0;
            m_fault = 1'b0; m_err = 0; m_good = 0;
        end else if (m_phase == 3) begin
            // faulted: nothing moves until cleared
        end else if (!en) begin
            if (m_phase != 0) begin
                m_phase = 0; m_run = 0; m_locked = 1'b0;
            end
        end else begin
            if (m_phase == 0) begin
                m_phase = 1; m_run = 0;
            end else if (m_phase == 1) begin
                m_run = (d == m_next) ? m_run + 1 : 0;
                if (m_run == 4) begin m_phase = 2; m_locked = 1'b1; end
            end else if (d == m_next) begin
                if (m_good < 32'hFFFF_FFFF) m_good++;
            end else begin
                m_mis = 1'b1;
                if (m_err < 16'hFFFF) m_err++;
                if (m_err >= 8) begin m_phase = 3; m_fault = 1'b1; m_locked = 1'b0; end
            end
            m_next = d + 8'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("locked",     {31'd0, locked},   {31'd0, m_locked});
        chk("mismatch",   {31'd0, mismatch}, {31'd0, m_mis});
        chk("fault",      {31'd0, fault},    {31'd0, m_fault});
        chk("err_count",  {16'd0, err_count}, m_err);
        chk("good_count", good_count,        m_good);
    endtask

    task automatic step(input logic en, input logic [7:0] d, input logic clr);
        @(negedge clk);
        enable    = en;
        data_in   = d;
        clr_stats = clr;
        @(posedge clk);
        model_edge(en, d, clr);
        #1;
        compare_all();
    endtask

    task automatic run(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) step(1'b1, first + 8'(i), 1'b0);
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        reset = 1'b0; enable = 1'b0; data_in = 8'h00; clr_stats = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_err",    {16'd0, err_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // T1: lock on 0x10..0x14
        run(8'h10, 4);
        chk("t1_not_yet_locked", {31'd0, locked}, 32'd0);
        step(1'b1, 8'h14, 1'b0);
        chk("t1_locked", {31'd0, locked}, 32'd1);
        run(8'h15, 3);
        chk("t1_good3", good_count, 32'd3);

        // T2: wrap through 0xFF
        step(1'b0, 8'h00, 1'b1);
        run(8'hF8, 5);
        run(8'hFD, 5);
        chk("t2_good5", good_count, 32'd5);
        chk("t2_err0",  {16'd0, err_count}, 32'd0);

        // T3: single injected error
        step(1'b0, 8'h00, 1'b1);
        run(8'h1C, 5);
        step(1'b1, 8'h30, 1'b0);
        chk("t3_pulse", {31'd0, mismatch}, 32'd1);
        chk("t3_err1",  {16'd0, err_count}, 32'd1);
        step(1'b1, 8'h31, 1'b0);
        chk("t3_pulse_gone", {31'd0, mismatch}, 32'd0);
        chk("t3_good1", good_count, 32'd1);
        chk("t3_still_locked", {31'd0, locked}, 32'd1);

        // T4: eight bad samples -> fault, then clear
        step(1'b0, 8'h00, 1'b1);
        run(8'h50, 5);
        for (int i = 1; i <= 8; i++) step(1'b1, 8'h54 + 8'(2 * i), 1'b0);
        chk("t4_fault",  {31'd0, fault},  32'd1);
        chk("t4_unlock", {31'd0, locked}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h90 + 8'(3 * i), 1'b0);
        chk("t4_err_frozen", {16'd0, err_count}, 32'd8);
        step(1'b1, 8'hAA, 1'b1);
        chk("t4_clr_err",   {16'd0, err_count}, 32'd0);
        chk("t4_clr_fault", {31'd0, fault}, 32'd0);

        // T5: pause mid-track, resume at 0x40
        run(8'h30, 7);
        step(1'b0, 8'h37, 1'b0);
        chk("t5_drop", {31'd0, locked}, 32'd0);
        step(1'b0, 8'h38, 1'b0);
        step(1'b0, 8'h39, 1'b0);
        run(8'h40, 4);
        chk("t5_relocking", {31'd0, locked}, 32'd0);
        step(1'b1, 8'h44, 1'b0);
        chk("t5_relocked",  {31'd0, locked}, 32'd1);
        chk("t5_good_kept", good_count, 32'd2);

        // T6: clr during a mismatch, then async reset mid-stream
        step(1'b1, 8'h60, 1'b0);
        chk("t6_err1", {16'd0, err_count}, 32'd1);
        step(1'b1, 8'h70, 1'b1);
        chk("t6_clr_err",  {16'd0, err_count}, 32'd0);
        chk("t6_clr_mis",  {31'd0, mismatch}, 32'd0);
        run(8'h00, 8);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("t6_rst_good", good_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run(8'hC0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
